// File: rtl/simple_pkg.sv
// Shared opcode and condition-flag definitions for the SIMPLE execute-stage shifter.
package simple_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_SLL = 4'd8;
    localparam opcode_t OP_SLR = 4'd9;
    localparam opcode_t OP_SRL = 4'd10;
    localparam opcode_t OP_SRA = 4'd11;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/shifter_level.sv
// One barrel level: shifts/rotates by 2^K when enabled, recording the bit shifted out.
module shifter_level
    import simple_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K     = 0
) (
    input  opcode_t          op,
    input  logic             en,
    input  logic             sign,
    input  logic [WIDTH-1:0] d,
    input  logic             c,
    output logic [WIDTH-1:0] q,
    output logic             cq
);

    localparam int S = 1 << K;

    always_comb begin
        q  = d;
        cq = c;
        if (en) begin
            case (op)
                OP_SLL: begin
                    q  = {d[WIDTH-S-1:0], {S{1'b0}}};
                    cq = d[WIDTH-S];
                end
                OP_SLR: begin
                    q  = {d[WIDTH-S-1:0], d[WIDTH-1:WIDTH-S]};
                    cq = d[WIDTH-S];
                end
                OP_SRL: begin
                    q  = {{S{1'b0}}, d[WIDTH-1:S]};
                    cq = d[S-1];
                end
                OP_SRA: begin
                    // fill comes from the original operand MSB, carried alongside the data
                    q  = {{S{sign}}, d[WIDTH-1:S]};
                    cq = d[S-1];
                end
                default: begin
                    q  = d;
                    cq = c;
                end
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined log2 barrel shifter (SLL/SLR/SRL/SRA) with valid/ready, flush and SZCV flags.
// Optional build macro SHIFTER_ROT_CARRY_EN: SLR reports C = result[0] when amt != 0.
module shifter_pipe
    import simple_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SHW      = $clog2(WIDTH),
    parameter int PIPE_ALL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       cond
);

    logic                      adv;
    logic [SHW-1:0]            lvl_valid;
    logic [SHW-1:0][3:0]       lvl_op;
    logic [SHW-1:0][SHW-1:0]   lvl_amt;
    logic [SHW-1:0]            lvl_sign;
    logic [SHW-1:0][WIDTH-1:0] lvl_d;
    logic [SHW-1:0][WIDTH-1:0] lvl_q;
    logic [SHW-1:0]            lvl_c;
    logic [SHW-1:0]            lvl_cq;

    logic [WIDTH-1:0]          fin_res;
    logic                      fin_c;
    logic [3:0]                fin_cond;

    // Single global stall: every register in the pipe moves together.
    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : g_level
            shifter_level #(
                .WIDTH (WIDTH),
                .K     (gi)
            ) u_level (
                .op   (lvl_op[gi]),
                .en   (lvl_amt[gi][gi]),
                .sign (lvl_sign[gi]),
                .d    (lvl_d[gi]),
                .c    (lvl_c[gi]),
                .q    (lvl_q[gi]),
                .cq   (lvl_cq[gi])
            );
        end

        if (PIPE_ALL != 0) begin : g_piped
            logic [SHW-2:0]            valid_reg;
            logic [SHW-2:0][3:0]       op_reg;
            logic [SHW-2:0][SHW-1:0]   amt_reg;
            logic [SHW-2:0]            sign_reg;
            logic [SHW-2:0][WIDTH-1:0] data_reg;
            logic [SHW-2:0]            carry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= '0;
                    op_reg    <= '0;
                    amt_reg   <= '0;
                    sign_reg  <= '0;
                    data_reg  <= '0;
                    carry_reg <= '0;
                end else if (flush) begin
                    valid_reg <= '0;
                end else if (adv) begin
                    valid_reg <= lvl_valid[SHW-2:0];
                    op_reg    <= lvl_op[SHW-2:0];
                    amt_reg   <= lvl_amt[SHW-2:0];
                    sign_reg  <= lvl_sign[SHW-2:0];
                    data_reg  <= lvl_q[SHW-2:0];
                    carry_reg <= lvl_cq[SHW-2:0];
                end
            end

            assign lvl_valid = {valid_reg, in_valid};
            assign lvl_op    = {op_reg, opcode};
            assign lvl_amt   = {amt_reg, amt};
            assign lvl_sign  = {sign_reg, a[WIDTH-1]};
            assign lvl_d     = {data_reg, a};
            assign lvl_c     = {carry_reg, 1'b0};
        end else begin : g_comb
            assign lvl_valid = {SHW{in_valid}};
            assign lvl_op    = {SHW{opcode}};
            assign lvl_amt   = {SHW{amt}};
            assign lvl_sign  = {SHW{a[WIDTH-1]}};
            assign lvl_d     = {lvl_q[SHW-2:0], a};
            assign lvl_c     = {lvl_cq[SHW-2:0], 1'b0};
        end
    endgenerate

    assign fin_res = lvl_q[SHW-1];

    always_comb begin
        fin_c = 1'b0;
        if (lvl_amt[SHW-1] != '0) begin
            case (lvl_op[SHW-1])
                OP_SLL, OP_SRL, OP_SRA: fin_c = lvl_cq[SHW-1];
`ifdef SHIFTER_ROT_CARRY_EN
                OP_SLR:                 fin_c = fin_res[0];
`endif
                default:                fin_c = 1'b0;
            endcase
        end
        fin_cond         = '0;
        fin_cond[FLAG_S] = fin_res[WIDTH-1];
        fin_cond[FLAG_Z] = (fin_res == '0);
        fin_cond[FLAG_C] = fin_c;
        fin_cond[FLAG_V] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            cond      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= lvl_valid[SHW-1];
            result    <= fin_res;
            cond      <= fin_cond;
        end
    end

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed-vector bench for shifter_pipe: one instance with PIPE_ALL=0, one with PIPE_ALL=1.
module tb_shifter_pipe;
    import simple_pkg::*;

    localparam int W   = 16;
    localparam int SHW = 4;
    localparam int NV  = 16;

`ifdef SHIFTER_ROT_CARRY_EN
    localparam logic [3:0] SLR_C = 4'b0010;
`else
    localparam logic [3:0] SLR_C = 4'b0000;
`endif

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic           flush     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b1;
    logic [3:0]     opcode    = '0;
    logic [W-1:0]   a         = '0;
    logic [SHW-1:0] amt       = '0;

    logic           in_ready0, out_valid0, in_ready1, out_valid1;
    logic [W-1:0]   result0, result1;
    logic [3:0]     cond0, cond1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0]     v_op   [NV];
    logic [W-1:0]   v_a    [NV];
    logic [SHW-1:0] v_amt  [NV];
    logic [W-1:0]   v_res  [NV];
    logic [3:0]     v_cond [NV];

    always #5 clk = ~clk;

    shifter_pipe #(.WIDTH(W), .PIPE_ALL(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .opcode(opcode), .a(a), .amt(amt), .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .cond(cond0)
    );

    shifter_pipe #(.WIDTH(W), .PIPE_ALL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .opcode(opcode), .a(a), .amt(amt), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .cond(cond1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic set_vec(input int i, input logic [3:0] op, input logic [W-1:0] va,
                           input logic [SHW-1:0] vamt, input logic [W-1:0] res, input logic [3:0] cd);
        v_op[i] = op; v_a[i] = va; v_amt[i] = vamt; v_res[i] = res; v_cond[i] = cd;
    endtask

    task automatic drive(input int i);
        opcode = v_op[i]; a = v_a[i]; amt = v_amt[i];
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issue one op to both instances and check result, flags and latency of each.
    task automatic run_single(input int i);
        int lat0, lat1;
        logic [W-1:0] r0, r1;
        logic [3:0]   c0, c1;
        lat0 = 0; lat1 = 0; r0 = '0; r1 = '0; c0 = '0; c1 = '0;
        drive(i); in_valid = 1'b1; out_ready = 1'b1;
        chk($sformatf("v%0d_in_ready", i), in_ready1, 1);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (out_valid0 && lat0 == 0) begin lat0 = c; r0 = result0; c0 = cond0; end
            if (out_valid1 && lat1 == 0) begin lat1 = c; r1 = result1; c1 = cond1; end
            tick();
        end
        $display("txn v%0d op=%0d a=%h amt=%0d -> pipe0 %h/%b lat %0d, pipe1 %h/%b lat %0d",
                 i, v_op[i], v_a[i], v_amt[i], r0, c0, lat0, r1, c1, lat1);
        chk($sformatf("v%0d_res0", i), r0, v_res[i]);
        chk($sformatf("v%0d_cond0", i), c0, v_cond[i]);
        chk($sformatf("v%0d_lat0", i), lat0, 1);
        chk($sformatf("v%0d_res1", i), r1, v_res[i]);
        chk($sformatf("v%0d_cond1", i), c1, v_cond[i]);
        chk($sformatf("v%0d_lat1", i), lat1, SHW);
    endtask

    int sidx [6] = '{8, 9, 10, 11, 14, 15};

    initial begin
        int sent, recv, first, seen;

        set_vec(0,  OP_SLL, 16'h8001, 4'd1,  16'h0002, 4'b0010);
        set_vec(1,  OP_SRA, 16'h8000, 4'd15, 16'hFFFF, 4'b1000);
        set_vec(2,  OP_SRL, 16'h0001, 4'd1,  16'h0000, 4'b0110);
        set_vec(3,  OP_SLR, 16'h8001, 4'd1,  16'h0003, SLR_C);
        set_vec(4,  OP_SLL, 16'h1234, 4'd0,  16'h1234, 4'b0000);
        set_vec(5,  OP_SRA, 16'h1234, 4'd0,  16'h1234, 4'b0000);
        set_vec(6,  OP_SLR, 16'h1234, 4'd0,  16'h1234, 4'b0000);
        set_vec(7,  4'd0,   16'hF00F, 4'd4,  16'hF00F, 4'b1000);
        set_vec(8,  OP_SRL, 16'hF00F, 4'd4,  16'h0F00, 4'b0010);
        set_vec(9,  OP_SRA, 16'hF00F, 4'd4,  16'hFF00, 4'b1010);
        set_vec(10, OP_SLL, 16'hF00F, 4'd4,  16'h00F0, 4'b0010);
        set_vec(11, OP_SLR, 16'hF00F, 4'd4,  16'h00FF, SLR_C);
        set_vec(12, OP_SLL, 16'h0001, 4'd15, 16'h8000, 4'b1000);
        set_vec(13, OP_SRL, 16'h8000, 4'd15, 16'h0001, 4'b0000);
        set_vec(14, OP_SLL, 16'h8000, 4'd1,  16'h0000, 4'b0110);
        set_vec(15, OP_SRA, 16'h7FFF, 4'd3,  16'h0FFF, 4'b0010);

        // Reset state
        #12;
        chk("rst_out_valid0", out_valid0, 0);
        chk("rst_out_valid1", out_valid1, 0);
        chk("rst_result1", result1, 0);
        chk("rst_cond1", cond1, 0);
        chk("rst_in_ready1", in_ready1, 1);
        @(posedge clk); #1; rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) run_single(i);

        // Back-to-back stream into the fully piped instance with a 3-cycle output stall
        sent = 0; recv = 0; first = -1;
        for (int cyc = 0; cyc < 30 && recv < 6; cyc++) begin
            in_valid = (sent < 6);
            if (sent < 6) drive(sidx[sent]);
            out_ready = !(cyc >= 5 && cyc <= 7);
            @(negedge clk);
            if (cyc >= 5 && cyc <= 7) chk($sformatf("stall_in_ready_c%0d", cyc), in_ready1, 0);
            else if (cyc < 5)         chk($sformatf("flow_in_ready_c%0d", cyc), in_ready1, 1);
            if (out_valid1 && first < 0) first = cyc;
            if (out_valid1 && out_ready) begin
                if (recv < 6) begin
                    $display("txn stream%0d cyc %0d result=%h cond=%b", recv, cyc, result1, cond1);
                    chk($sformatf("stream%0d_res", recv), result1, v_res[sidx[recv]]);
                    chk($sformatf("stream%0d_cond", recv), cond1, v_cond[sidx[recv]]);
                end
                recv++;
            end
            if (in_valid && in_ready1) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", recv, 6);
        chk("stream_first_valid", first, SHW);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid1) seen++;
            tick();
        end
        chk("stream_no_dup", seen, 0);

        // Flush with three ops in flight plus one presented in the flush cycle
        for (int k = 0; k < 3; k++) begin
            drive(8 + k); in_valid = 1'b1; tick();
        end
        drive(12); in_valid = 1'b1; flush = 1'b1;
        chk("flush_in_ready", in_ready1, 1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        $display("txn flush out_valid0=%b out_valid1=%b", out_valid0, out_valid1);
        chk("flush_out_valid0", out_valid0, 0);
        chk("flush_out_valid1", out_valid1, 0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid0 || out_valid1) seen++;
            tick();
        end
        chk("flush_no_ghosts", seen, 0);
        run_single(13);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 5; k++) begin
            drive(9 + k); in_valid = 1'b1; tick();
        end
        chk("pre_rst_out_valid1", out_valid1, 1);
        #2 rst_n = 1'b0;
        #1;
        $display("txn async_reset out_valid1=%b result1=%h cond1=%b", out_valid1, result1, cond1);
        chk("arst_out_valid0", out_valid0, 0);
        chk("arst_out_valid1", out_valid1, 0);
        chk("arst_result1", result1, 0);
        chk("arst_cond1", cond1, 0);
        in_valid = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        tick();
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid1) seen++;
            tick();
        end
        chk("arst_no_ghosts", seen, 0);
        run_single(9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
